// File: rtl/mem_lsu_if.sv
// Data-RAM bus between the MEM-stage load/store unit and the data memory.
//
// Handshake: dram_req is a request-valid that, once raised, holds
// dram_we/dram_addr/dram_be/dram_wdata stable until the cycle dram_ready is
// high (request accepted on that clock edge). For reads, the memory then
// returns dram_rdata with dram_rvalid high for one cycle, at least one cycle
// after acceptance.
//
// Modports:
//   master - load/store unit: drives req/we/addr/be/wdata, receives ready/rvalid/rdata
//   slave  - data RAM: the reverse
interface mem_lsu_if #(
    parameter int XLEN    = 32,
    parameter int DRAM_AW = 12
);
    logic               dram_req;
    logic               dram_we;
    logic [DRAM_AW-1:0] dram_addr;
    logic [3:0]         dram_be;
    logic [XLEN-1:0]    dram_wdata;
    logic               dram_ready;
    logic               dram_rvalid;
    logic [XLEN-1:0]    dram_rdata;

    modport master (
        output dram_req, dram_we, dram_addr, dram_be, dram_wdata,
        input  dram_ready, dram_rvalid, dram_rdata
    );

    modport slave (
        input  dram_req, dram_we, dram_addr, dram_be, dram_wdata,
        output dram_ready, dram_rvalid, dram_rdata
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit between EX and WB.
//
// Non-memory instructions pass through to the mem_* registers in one cycle.
// Loads/stores run one req/ready(/rvalid) transaction on the data-RAM bus
// while mem_stall holds EX. Illegal or misaligned memory ops never touch the
// bus; they are flagged on mem_ill_instr (and mem_misalign) with no writeback.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   ex_*             EX-stage results and memory-op controls
//   mem_stall        hold EX outputs stable (registered state only)
//   mem_*            registered results towards WB
//   dram             data-RAM bus (master side)
//   dbg_state        current FSM state (IDLE=0, REQ=1, RDATA=2)
module mem_lsu #(
    parameter int XLEN    = 32,
    parameter int RF_AW   = 5,
    parameter int DRAM_AW = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_reg_wen,
    input  logic [RF_AW-1:0] ex_reg_waddr,
    input  logic [XLEN-1:0]  ex_alu_out,
    input  logic             ex_ill_instr,
    input  logic             ex_mem_rd,
    input  logic             ex_mem_wr,
    input  logic [1:0]       ex_mem_size,
    input  logic             ex_mem_unsigned,
    input  logic [XLEN-1:0]  ex_mem_wdata,
    output logic             mem_stall,
    output logic             mem_reg_wen,
    output logic [RF_AW-1:0] mem_reg_waddr,
    output logic [XLEN-1:0]  mem_alu_out,
    output logic             mem_ill_instr,
    output logic             mem_misalign,
    mem_lsu_if.master        dram,
    output logic [1:0]       dbg_state
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_RDATA = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               mem_reg_wen_q, mem_reg_wen_d;
    logic [RF_AW-1:0]   mem_reg_waddr_q, mem_reg_waddr_d;
    logic [XLEN-1:0]    mem_alu_out_q, mem_alu_out_d;
    logic               mem_ill_instr_q, mem_ill_instr_d;
    logic               mem_misalign_q, mem_misalign_d;
    logic               dram_req_q, dram_req_d;
    logic               dram_we_q, dram_we_d;
    logic [DRAM_AW-1:0] dram_addr_q, dram_addr_d;
    logic [3:0]         dram_be_q, dram_be_d;
    logic [XLEN-1:0]    dram_wdata_q, dram_wdata_d;
    // Attributes of the in-flight access, needed after EX has moved on.
    logic [XLEN-1:0]    lat_addr_q, lat_addr_d;
    logic [1:0]         lat_size_q, lat_size_d;
    logic               lat_uns_q, lat_uns_d;
    logic [RF_AW-1:0]   lat_waddr_q, lat_waddr_d;
    logic               lat_wen_q, lat_wen_d;

    logic            is_mem, bad_op, misalign;
    logic [XLEN-1:0] rd_shifted, load_data, st_wdata;
    logic [3:0]      st_be;

    always_comb begin
        is_mem   = ex_mem_rd | ex_mem_wr;
        bad_op   = ex_ill_instr | (ex_mem_rd & ex_mem_wr) | (ex_mem_size == 2'b11);
        misalign = ((ex_mem_size == 2'b01) & ex_alu_out[0]) |
                   ((ex_mem_size == 2'b10) & (ex_alu_out[1:0] != 2'b00));

        // Store lane placement: replicate the datum across the word, enable its lanes.
        case (ex_mem_size)
            2'b00: begin
                st_be    = 4'b0001 << ex_alu_out[1:0];
                st_wdata = {(XLEN/8){ex_mem_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << ex_alu_out[1:0];
                st_wdata = {(XLEN/16){ex_mem_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'hF;
                st_wdata = ex_mem_wdata;
            end
        endcase

        // Load alignment: bring the addressed lane down to bit 0, then extend.
        rd_shifted = dram.dram_rdata >> {lat_addr_q[1:0], 3'b000};
        case (lat_size_q)
            2'b00:   load_data = lat_uns_q ? {{(XLEN-8){1'b0}}, rd_shifted[7:0]}
                                           : {{(XLEN-8){rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   load_data = lat_uns_q ? {{(XLEN-16){1'b0}}, rd_shifted[15:0]}
                                           : {{(XLEN-16){rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_data = dram.dram_rdata;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        mem_reg_wen_d   = mem_reg_wen_q;
        mem_reg_waddr_d = mem_reg_waddr_q;
        mem_alu_out_d   = mem_alu_out_q;
        mem_ill_instr_d = mem_ill_instr_q;
        mem_misalign_d  = mem_misalign_q;
        dram_req_d      = dram_req_q;
        dram_we_d       = dram_we_q;
        dram_addr_d     = dram_addr_q;
        dram_be_d       = dram_be_q;
        dram_wdata_d    = dram_wdata_q;
        lat_addr_d      = lat_addr_q;
        lat_size_d      = lat_size_q;
        lat_uns_d       = lat_uns_q;
        lat_waddr_d     = lat_waddr_q;
        lat_wen_d       = lat_wen_q;

        case (state_q)
            S_IDLE: begin
                mem_reg_waddr_d = ex_reg_waddr;
                mem_alu_out_d   = ex_alu_out;
                if (!is_mem) begin
                    mem_reg_wen_d   = ex_reg_wen;
                    mem_ill_instr_d = ex_ill_instr;
                    mem_misalign_d  = 1'b0;
                end else if (bad_op || misalign) begin
                    // Faulting memory op: report it, never reach the bus.
                    mem_reg_wen_d   = 1'b0;
                    mem_ill_instr_d = 1'b1;
                    mem_misalign_d  = misalign;
                end else begin
                    // Legal access: bubble towards WB while the transaction runs.
                    mem_reg_wen_d   = 1'b0;
                    mem_ill_instr_d = 1'b0;
                    mem_misalign_d  = 1'b0;
                    lat_addr_d      = ex_alu_out;
                    lat_size_d      = ex_mem_size;
                    lat_uns_d       = ex_mem_unsigned;
                    lat_waddr_d     = ex_reg_waddr;
                    lat_wen_d       = ex_reg_wen;
                    dram_req_d      = 1'b1;
                    dram_we_d       = ex_mem_wr;
                    dram_addr_d     = ex_alu_out[DRAM_AW+1:2];
                    dram_be_d       = ex_mem_wr ? st_be : 4'hF;
                    dram_wdata_d    = ex_mem_wr ? st_wdata : '0;
                    state_d         = S_REQ;
                end
            end
            S_REQ: begin
                mem_reg_wen_d = 1'b0;
                if (dram.dram_ready) begin
                    dram_req_d = 1'b0;
                    if (dram_we_q) begin
                        mem_reg_waddr_d = lat_waddr_q;
                        mem_alu_out_d   = lat_addr_q;
                        mem_ill_instr_d = 1'b0;
                        mem_misalign_d  = 1'b0;
                        state_d         = S_IDLE;
                    end else begin
                        state_d = S_RDATA;
                    end
                end
            end
            S_RDATA: begin
                mem_reg_wen_d = 1'b0;
                if (dram.dram_rvalid) begin
                    mem_reg_wen_d   = lat_wen_q;
                    mem_reg_waddr_d = lat_waddr_q;
                    mem_alu_out_d   = load_data;
                    mem_ill_instr_d = 1'b0;
                    mem_misalign_d  = 1'b0;
                    state_d         = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= S_IDLE;
            mem_reg_wen_q   <= 1'b0;
            mem_reg_waddr_q <= '0;
            mem_alu_out_q   <= '0;
            mem_ill_instr_q <= 1'b0;
            mem_misalign_q  <= 1'b0;
            dram_req_q      <= 1'b0;
            dram_we_q       <= 1'b0;
            dram_addr_q     <= '0;
            dram_be_q       <= 4'h0;
            dram_wdata_q    <= '0;
            lat_addr_q      <= '0;
            lat_size_q      <= 2'b00;
            lat_uns_q       <= 1'b0;
            lat_waddr_q     <= '0;
            lat_wen_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            mem_reg_wen_q   <= mem_reg_wen_d;
            mem_reg_waddr_q <= mem_reg_waddr_d;
            mem_alu_out_q   <= mem_alu_out_d;
            mem_ill_instr_q <= mem_ill_instr_d;
            mem_misalign_q  <= mem_misalign_d;
            dram_req_q      <= dram_req_d;
            dram_we_q       <= dram_we_d;
            dram_addr_q     <= dram_addr_d;
            dram_be_q       <= dram_be_d;
            dram_wdata_q    <= dram_wdata_d;
            lat_addr_q      <= lat_addr_d;
            lat_size_q      <= lat_size_d;
            lat_uns_q       <= lat_uns_d;
            lat_waddr_q     <= lat_waddr_d;
            lat_wen_q       <= lat_wen_d;
        end
    end

    assign mem_stall       = (state_q != S_IDLE);
    assign mem_reg_wen     = mem_reg_wen_q;
    assign mem_reg_waddr   = mem_reg_waddr_q;
    assign mem_alu_out     = mem_alu_out_q;
    assign mem_ill_instr   = mem_ill_instr_q;
    assign mem_misalign    = mem_misalign_q;
    assign dram.dram_req   = dram_req_q;
    assign dram.dram_we    = dram_we_q;
    assign dram.dram_addr  = dram_addr_q;
    assign dram.dram_be    = dram_be_q;
    assign dram.dram_wdata = dram_wdata_q;
    assign dbg_state       = state_q;
endmodule

// File: tb/tb_mem_lsu.sv
module tb_mem_lsu;
    logic        clk;
    logic        rst;
    logic        ex_reg_wen;
    logic [4:0]  ex_reg_waddr;
    logic [31:0] ex_alu_out;
    logic        ex_ill_instr;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic [1:0]  ex_mem_size;
    logic        ex_mem_unsigned;
    logic [31:0] ex_mem_wdata;
    logic        mem_stall;
    logic        mem_reg_wen;
    logic [4:0]  mem_reg_waddr;
    logic [31:0] mem_alu_out;
    logic        mem_ill_instr;
    logic        mem_misalign;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    mem_lsu_if #(.XLEN(32), .DRAM_AW(12)) dram_if ();

    mem_lsu dut (
        .clk(clk), .rst(rst),
        .ex_reg_wen(ex_reg_wen), .ex_reg_waddr(ex_reg_waddr), .ex_alu_out(ex_alu_out),
        .ex_ill_instr(ex_ill_instr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
        .ex_mem_size(ex_mem_size), .ex_mem_unsigned(ex_mem_unsigned), .ex_mem_wdata(ex_mem_wdata),
        .mem_stall(mem_stall), .mem_reg_wen(mem_reg_wen), .mem_reg_waddr(mem_reg_waddr),
        .mem_alu_out(mem_alu_out), .mem_ill_instr(mem_ill_instr), .mem_misalign(mem_misalign),
        .dram(dram_if), .dbg_state(dbg_state)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change on the falling edge, outputs are checked there too.
    task automatic set_nop();
        ex_reg_wen = 0; ex_reg_waddr = 0; ex_alu_out = 0; ex_ill_instr = 0;
        ex_mem_rd = 0; ex_mem_wr = 0; ex_mem_size = 0; ex_mem_unsigned = 0; ex_mem_wdata = 0;
    endtask

    task automatic set_mem(input logic rd, input logic wr, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic wen, input logic [4:0] waddr);
        set_nop();
        ex_mem_rd = rd; ex_mem_wr = wr; ex_mem_size = size; ex_mem_unsigned = uns;
        ex_alu_out = addr; ex_mem_wdata = wdata; ex_reg_wen = wen; ex_reg_waddr = waddr;
    endtask

    task automatic test_reset();
        set_nop();
        dram_if.dram_ready = 0; dram_if.dram_rvalid = 0; dram_if.dram_rdata = 0;
        rst = 1;
        repeat (2) @(negedge clk);
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
        checks++; if ({mem_stall, mem_reg_wen, mem_reg_waddr, mem_alu_out, mem_ill_instr, mem_misalign} !== '0) begin
            errors++; $display("FAIL reset_mem_outs got stall=%b wen=%b waddr=%0d out=%h ill=%b mis=%b exp all 0",
                               mem_stall, mem_reg_wen, mem_reg_waddr, mem_alu_out, mem_ill_instr, mem_misalign); end
        checks++; if ({dram_if.dram_req, dram_if.dram_we, dram_if.dram_addr, dram_if.dram_be, dram_if.dram_wdata} !== '0) begin
            errors++; $display("FAIL reset_dram_outs got req=%b we=%b addr=%h be=%h wdata=%h exp all 0",
                               dram_if.dram_req, dram_if.dram_we, dram_if.dram_addr, dram_if.dram_be, dram_if.dram_wdata); end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        set_nop(); ex_reg_wen = 1; ex_reg_waddr = 5; ex_alu_out = 32'h1234;
        @(negedge clk);
        checks++; if (mem_reg_wen !== 1'b1) begin errors++; $display("FAIL alu_wen got %b exp 1", mem_reg_wen); end
        checks++; if (mem_reg_waddr !== 5'd5) begin errors++; $display("FAIL alu_waddr got %0d exp 5", mem_reg_waddr); end
        checks++; if (mem_alu_out !== 32'h1234) begin errors++; $display("FAIL alu_out got %h exp 00001234", mem_alu_out); end
        checks++; if (mem_stall !== 1'b0 || mem_misalign !== 1'b0) begin
            errors++; $display("FAIL alu_stall_mis got stall=%b mis=%b exp 0 0", mem_stall, mem_misalign); end
        set_nop();
        @(negedge clk);
    endtask

    // Loads: issue, accept on first REQ cycle, rvalid in the first RDATA cycle.
    task automatic test_loads();
        logic [31:0] addr_t [4] = '{32'h103, 32'h103, 32'h102, 32'h3FFC};
        logic [1:0]  size_t [4] = '{2'd0, 2'd0, 2'd1, 2'd2};
        logic        uns_t  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [31:0] rd_t   [4] = '{32'h80FF_0000, 32'h80FF_0000, 32'h80FF_0000, 32'hDEAD_BEEF};
        logic [31:0] exp_t  [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'hDEAD_BEEF};
        logic [11:0] ea_t   [4] = '{12'h040, 12'h040, 12'h040, 12'hFFF};
        for (int i = 0; i < 4; i++) begin
            set_mem(1, 0, size_t[i], uns_t[i], addr_t[i], 32'h0, 1, 5'(7 + i));
            @(negedge clk);
            set_nop();
            checks++; if (dram_if.dram_req !== 1'b1 || dram_if.dram_we !== 1'b0 || dram_if.dram_be !== 4'hF) begin
                errors++; $display("FAIL load%0d_req got req=%b we=%b be=%h exp 1 0 f", i, dram_if.dram_req, dram_if.dram_we, dram_if.dram_be); end
            checks++; if (dram_if.dram_addr !== ea_t[i]) begin errors++; $display("FAIL load%0d_addr got %h exp %h", i, dram_if.dram_addr, ea_t[i]); end
            checks++; if (mem_stall !== 1'b1 || mem_reg_wen !== 1'b0) begin
                errors++; $display("FAIL load%0d_bubble got stall=%b wen=%b exp 1 0", i, mem_stall, mem_reg_wen); end
            dram_if.dram_ready = 1;
            @(negedge clk);
            dram_if.dram_ready = 0;
            checks++; if (dbg_state !== 2'd2 || dram_if.dram_req !== 1'b0) begin
                errors++; $display("FAIL load%0d_rdata_state got st=%0d req=%b exp 2 0", i, dbg_state, dram_if.dram_req); end
            dram_if.dram_rvalid = 1; dram_if.dram_rdata = rd_t[i];
            @(negedge clk);
            dram_if.dram_rvalid = 0; dram_if.dram_rdata = 32'h0;
            checks++; if (mem_alu_out !== exp_t[i]) begin errors++; $display("FAIL load%0d_data got %h exp %h", i, mem_alu_out, exp_t[i]); end
            checks++; if (mem_reg_wen !== 1'b1 || mem_reg_waddr !== 5'(7 + i) || mem_stall !== 1'b0) begin
                errors++; $display("FAIL load%0d_wb got wen=%b waddr=%0d stall=%b exp 1 %0d 0", i, mem_reg_wen, mem_reg_waddr, mem_stall, 7 + i); end
        end
        @(negedge clk);
    endtask

    // Stores: ready withheld until the third REQ cycle.
    task automatic test_stores();
        logic [31:0] addr_t [3] = '{32'h102, 32'h101, 32'h100};
        logic [1:0]  size_t [3] = '{2'd1, 2'd0, 2'd2};
        logic [31:0] wd_t   [3] = '{32'h0000_ABCD, 32'h1234_5655, 32'h0BAD_F00D};
        logic [3:0]  be_t   [3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [31:0] lane_t [3] = '{32'hABCD_ABCD, 32'h5555_5555, 32'h0BAD_F00D};
        int req_cycles;
        for (int i = 0; i < 3; i++) begin
            set_mem(0, 1, size_t[i], 0, addr_t[i], wd_t[i], 0, 5'd0);
            @(negedge clk);
            set_nop();
            checks++; if (dram_if.dram_be !== be_t[i] || dram_if.dram_wdata !== lane_t[i] || dram_if.dram_we !== 1'b1) begin
                errors++; $display("FAIL store%0d_lanes got be=%b wdata=%h we=%b exp %b %h 1", i, dram_if.dram_be, dram_if.dram_wdata, dram_if.dram_we, be_t[i], lane_t[i]); end
            checks++; if (dram_if.dram_addr !== 12'h040) begin errors++; $display("FAIL store%0d_addr got %h exp 040", i, dram_if.dram_addr); end
            req_cycles = 0;
            for (int c = 0; c < 3; c++) begin
                if (dram_if.dram_req === 1'b1 && mem_stall === 1'b1 && mem_reg_wen === 1'b0) req_cycles++;
                if (c == 2) dram_if.dram_ready = 1;
                else @(negedge clk);
            end
            @(negedge clk);
            dram_if.dram_ready = 0;
            checks++; if (req_cycles !== 3) begin errors++; $display("FAIL store%0d_req_held got %0d cycles exp 3", i, req_cycles); end
            checks++; if (dram_if.dram_req !== 1'b0 || mem_stall !== 1'b0 || dbg_state !== 2'd0 || mem_reg_wen !== 1'b0) begin
                errors++; $display("FAIL store%0d_done got req=%b stall=%b st=%0d wen=%b exp 0 0 0 0", i, dram_if.dram_req, mem_stall, dbg_state, mem_reg_wen); end
        end
        @(negedge clk);
    endtask

    // Faulting memory ops never reach the bus.
    task automatic test_faults();
        logic        rd_t   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic        wr_t   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0]  size_t [4] = '{2'd2, 2'd1, 2'd3, 2'd0};
        logic [31:0] addr_t [4] = '{32'h101, 32'h203, 32'h100, 32'h100};
        logic        mis_t  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            set_mem(rd_t[i], wr_t[i], size_t[i], 0, addr_t[i], 32'h0, 1, 5'd3);
            @(negedge clk);
            set_nop();
            checks++; if (dram_if.dram_req !== 1'b0 || mem_stall !== 1'b0) begin
                errors++; $display("FAIL fault%0d_noreq got req=%b stall=%b exp 0 0", i, dram_if.dram_req, mem_stall); end
            checks++; if (mem_ill_instr !== 1'b1 || mem_misalign !== mis_t[i] || mem_reg_wen !== 1'b0) begin
                errors++; $display("FAIL fault%0d_flags got ill=%b mis=%b wen=%b exp 1 %b 0", i, mem_ill_instr, mem_misalign, mem_reg_wen, mis_t[i]); end
        end
        @(negedge clk);
        checks++; if (mem_ill_instr !== 1'b0 || mem_misalign !== 1'b0) begin
            errors++; $display("FAIL fault_clear got ill=%b mis=%b exp 0 0", mem_ill_instr, mem_misalign); end
    endtask

    // Load then an ALU op held by stall; rvalid two cycles after acceptance.
    task automatic test_back_to_back();
        set_mem(1, 0, 2'd2, 0, 32'h200, 32'h0, 1, 5'd3);
        @(negedge clk);
        set_nop(); ex_reg_wen = 1; ex_reg_waddr = 9; ex_alu_out = 32'hBEEF;
        // Stray rvalid alongside acceptance must be ignored.
        dram_if.dram_ready = 1; dram_if.dram_rvalid = 1; dram_if.dram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dram_if.dram_ready = 0; dram_if.dram_rvalid = 0; dram_if.dram_rdata = 0;
        checks++; if (dbg_state !== 2'd2 || mem_reg_wen !== 1'b0 || mem_stall !== 1'b1) begin
            errors++; $display("FAIL b2b_wait1 got st=%0d wen=%b stall=%b exp 2 0 1", dbg_state, mem_reg_wen, mem_stall); end
        @(negedge clk);
        checks++; if (dbg_state !== 2'd2 || mem_reg_wen !== 1'b0) begin
            errors++; $display("FAIL b2b_wait2 got st=%0d wen=%b exp 2 0", dbg_state, mem_reg_wen); end
        dram_if.dram_rvalid = 1; dram_if.dram_rdata = 32'h1122_3344;
        @(negedge clk);
        dram_if.dram_rvalid = 0; dram_if.dram_rdata = 0;
        checks++; if (mem_reg_wen !== 1'b1 || mem_reg_waddr !== 5'd3 || mem_alu_out !== 32'h1122_3344 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL b2b_load got wen=%b waddr=%0d out=%h stall=%b exp 1 3 11223344 0", mem_reg_wen, mem_reg_waddr, mem_alu_out, mem_stall); end
        @(negedge clk);
        set_nop();
        checks++; if (mem_reg_wen !== 1'b1 || mem_reg_waddr !== 5'd9 || mem_alu_out !== 32'hBEEF) begin
            errors++; $display("FAIL b2b_alu got wen=%b waddr=%0d out=%h exp 1 9 0000beef", mem_reg_wen, mem_reg_waddr, mem_alu_out); end
        @(negedge clk);
    endtask

    // Asynchronous reset in REQ and in RDATA.
    task automatic test_reset_mid();
        set_mem(1, 0, 2'd2, 0, 32'h300, 32'h0, 1, 5'd4);
        @(negedge clk);
        set_nop();
        rst = 1; #1;
        checks++; if (dram_if.dram_req !== 1'b0 || dbg_state !== 2'd0 || mem_stall !== 1'b0) begin
            errors++; $display("FAIL rst_req got req=%b st=%0d stall=%b exp 0 0 0", dram_if.dram_req, dbg_state, mem_stall); end
        @(negedge clk);
        rst = 0;
        set_mem(1, 0, 2'd2, 0, 32'h300, 32'h0, 1, 5'd4);
        @(negedge clk);
        set_nop();
        dram_if.dram_ready = 1;
        @(negedge clk);
        dram_if.dram_ready = 0;
        checks++; if (dbg_state !== 2'd2) begin errors++; $display("FAIL rst_pre_rdata got st=%0d exp 2", dbg_state); end
        rst = 1; #1;
        checks++; if (dbg_state !== 2'd0 || mem_stall !== 1'b0 || mem_reg_wen !== 1'b0 || mem_alu_out !== 32'h0) begin
            errors++; $display("FAIL rst_rdata got st=%0d stall=%b wen=%b out=%h exp 0 0 0 0", dbg_state, mem_stall, mem_reg_wen, mem_alu_out); end
        @(negedge clk);
        rst = 0;
        dram_if.dram_rvalid = 1; dram_if.dram_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dram_if.dram_rvalid = 0; dram_if.dram_rdata = 0;
        checks++; if (mem_reg_wen !== 1'b0 || mem_alu_out !== 32'h0 || dbg_state !== 2'd0 || dram_if.dram_req !== 1'b0) begin
            errors++; $display("FAIL rst_late_rvalid got wen=%b out=%h st=%0d req=%b exp 0 0 0 0", mem_reg_wen, mem_alu_out, dbg_state, dram_if.dram_req); end
    endtask

    initial begin
        rst = 1;
        test_reset();
        test_alu();
        test_loads();
        test_stores();
        test_faults();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Overall time bound so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout exp finish before 200000");
        $fatal(1);
    end
endmodule
